// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and index helpers for the FFT output reorder
package fft_pkg;

    localparam int INT_WIDTH_DEF = 8;
    localparam int FRA_WIDTH_DEF = 16;
    localparam int SAMPLE_WIDTH  = INT_WIDTH_DEF + FRA_WIDTH_DEF;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    // Smallest r with 2**r >= v.
    function automatic int log2(input int unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] k, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) r[w-1-i] = k[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// rtl/fft_reorder_bank.sv - one ping-pong bank: write port plus registered read port
module fft_reorder_bank
    import fft_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = log2(DEPTH),
    parameter int DW    = 2 * SAMPLE_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    // Read register holds between bursts so the output stays at its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_rd_data <= '0;
        else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fft_reorder.sv
// rtl/fft_reorder.sv - bit-reversed to natural order frame reorder with ping-pong banks
module fft_reorder
    import fft_pkg::*;
#(
    parameter int N         = 16,
    parameter int INT_WIDTH = INT_WIDTH_DEF,
    parameter int FRA_WIDTH = FRA_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         di_en,
    input  logic [INT_WIDTH+FRA_WIDTH-1:0] di_re,
    input  logic [INT_WIDTH+FRA_WIDTH-1:0] di_im,
    output logic                         do_en,
    output logic [INT_WIDTH+FRA_WIDTH-1:0] do_re,
    output logic [INT_WIDTH+FRA_WIDTH-1:0] do_im,
    output logic                         ovf
);

    localparam int LOG_N = log2(N);
    localparam int DW    = INT_WIDTH + FRA_WIDTH;
    localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);

    rd_state_t        r_state, w_state_nxt;
    logic [LOG_N-1:0] r_wr_cnt, r_rd_cnt, w_rd_addr;
    logic             r_wr_bank, r_rd_bank, r_out_bank, r_do_en, r_ovf;
    logic [1:0]       r_full, w_full_nxt;
    logic             w_rd_active, w_rd_done, w_wr_ok, w_wr_fire, w_frame_done;
    logic [2*DW-1:0]  w_wr_data;
    logic [2*DW-1:0]  w_rd_data [2];

    assign w_rd_active  = (r_state == RD_READ);
    assign w_rd_done    = w_rd_active && (r_rd_cnt == LAST);
    // A bank whose last read issues this edge may take the next frame's first sample.
    assign w_wr_ok      = !r_full[r_wr_bank] || (w_rd_done && (r_rd_bank == r_wr_bank));
    assign w_wr_fire    = di_en && w_wr_ok;
    assign w_frame_done = w_wr_fire && (r_wr_cnt == LAST);
    assign w_rd_addr    = LOG_N'(bitrev(32'(r_rd_cnt), LOG_N));
    assign w_wr_data    = {di_re, di_im};

    always_comb begin
        w_full_nxt = r_full;
        if (w_rd_done)    w_full_nxt[r_rd_bank] = 1'b0;
        if (w_frame_done) w_full_nxt[r_wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RD_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RD_IDLE: if (r_full[r_rd_bank]) w_state_nxt = RD_READ;
            RD_READ: if (w_rd_done && !r_full[~r_rd_bank]) w_state_nxt = RD_IDLE;
            default: w_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt   <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_cnt   <= '0;
            r_rd_bank  <= 1'b0;
            r_out_bank <= 1'b0;
            r_full     <= '0;
            r_do_en    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                r_wr_cnt <= r_wr_cnt + LOG_N'(1);
                if (w_frame_done) r_wr_bank <= ~r_wr_bank;
            end
            if (di_en && !w_wr_ok) r_ovf <= 1'b1;
            r_full <= w_full_nxt;
            // rd_cnt wraps to zero at frame end, so a fresh READ always starts at 0.
            if (w_rd_active) begin
                r_rd_cnt   <= r_rd_cnt + LOG_N'(1);
                r_out_bank <= r_rd_bank;
                if (w_rd_done) r_rd_bank <= ~r_rd_bank;
            end
            r_do_en <= w_rd_active;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft_reorder_bank #(
            .DEPTH (N),
            .AW    (LOG_N),
            .DW    (2 * DW)
        ) u_bank (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_wr_en   (w_wr_fire && (r_wr_bank == 1'(g))),
            .i_wr_addr (r_wr_cnt),
            .i_wr_data (w_wr_data),
            .i_rd_en   (w_rd_active && (r_rd_bank == 1'(g))),
            .i_rd_addr (w_rd_addr),
            .o_rd_data (w_rd_data[g])
        );
    end

    assign do_en = r_do_en;
    assign do_re = w_rd_data[r_out_bank][2*DW-1:DW];
    assign do_im = w_rd_data[r_out_bank][DW-1:0];
    assign ovf   = r_ovf;

endmodule
